proc_core_mc: RTL and testbench
===============================

// Module: proc_core_mc
// PURPOSE
//  Parametrised multicycle 16-bit-ISA processor core with an explicit FETCH/DECODE/EXEC/WB state machine.
//  Successor to the single-width core: generic data/PC width, instruction-memory wait states, branch offsets, HALT, debug OUT port.
//  Sits between the instruction ROM (req/valid handshake) and board-level debug logic. Register file, ALU and control are internal.
// PARAMETERS
//  DATA_W    16   register/ALU width in bits; must be >= 8
//  PC_W      12   program counter width in bits; must be <= 12
//  RESET_PC  0    PC value loaded on reset
// PORTS
//  CLOCK_50     in   1       single clock; all state updates on the rising edge
//  reset        in   1       synchronous, active-low reset
//  imem_req     out  1       fetch request; held high from FETCH entry until imem_valid is sampled
//  imem_addr    out  PC_W    fetch address (= pc); stable while imem_req=1
//  imem_valid   in   1       imem_rdata valid; sampled only while imem_req=1
//  imem_rdata   in   16      instruction word
//  pc           out  PC_W    current program counter
//  out_valid    out  1       one-cycle pulse when an OUT instruction writes back
//  out_data     out  DATA_W  R[rs] of the last OUT; holds its value between pulses
//  halted       out  1       high once HALT executes; stays high until reset
// BEHAVIOUR
//  Encoding: op=[15:12] rd=[11:8] rs=[7:4] rt=[3:0]; imm4=[7:4]; imm8=[7:0]; imm12=[11:0].
//  Opcodes: 0 ADD rd=rs+rt | 1 SUB rd=rs-rt | 2 AND | 3 OR | 4 XOR | 5 SLT rd=(signed rs<rt)?1:0
//   6 ADDI rd=rt+zext(imm4) | 7 SHLI rd=rt<<imm4 | 8 SHRI rd=rt>>imm4 (logical) | 9 LI rd=zext(imm8)
//   10 BEQZ: if R[rd]==0 then pc=pc+1+sext(imm8) | 11 BNEZ: same test inverted | 12 JMP pc=imm12[PC_W-1:0]
//   13 OUT out_data=R[rs] | 14 NOP | 15 HALT. All 16 opcodes are defined.
//  R0 always reads 0; writes to R0 are discarded. R1..R15 are DATA_W bits wide.
//  Arithmetic is modulo 2^DATA_W. A shift amount >= DATA_W yields 0. The PC wraps modulo 2^PC_W.
//  The sext(imm8) offset is sign-extended or truncated to PC_W bits.
//  FSM states: FETCH, DECODE, EXEC, WB, HALT.
//   FETCH: imem_req=1. When imem_valid=1 is sampled: latch IR, go to DECODE. Otherwise stay; addr stays stable.
//   DECODE: latch A=R[rs] (R[rd] for branches) and B=R[rt]; go to EXEC.
//   EXEC: latch the ALU result and the zero flag (A==0); go to WB.
//   WB: write rd (opcodes 0-9 only); compute the next PC; pulse out_valid for OUT. HALT op -> HALT, otherwise -> FETCH.
//   HALT: halted=1, imem_req=0, no state changes; only reset exits.
//  Next PC in WB: taken branch -> pc+1+off; JMP -> imm12; otherwise pc+1.
//  Latency: 4 cycles per instruction with zero-wait memory (imem_valid high in the first FETCH cycle); +1 cycle per wait cycle.
//  The register write and the PC update take effect at the WB clock edge and are visible to the next DECODE.
//  Reset (reset=0 at an edge), from any state including mid-fetch or HALT:
//   pc=RESET_PC, state=FETCH, R1..R15=0, IR=0, out_data=0, out_valid=0, halted=0.
//   imem_req=0 while reset is low; any in-flight fetch is abandoned.
//   The memory shares the same reset and must drop outstanding requests.
//  imem_valid outside FETCH is ignored. imem_rdata is not required to be stable outside the sampling edge.
// TESTING
//  T1 reset: hold reset=0 3 cycles mid-program -> pc=0, halted=0, imem_req=0; 1st cycle after release imem_req=1, imem_addr=0.
//  T2 ALU: LI r1,5; LI r2,7; ADD r3,r1,r2; OUT r3 -> out_valid pulses once, out_data=12, exactly 16 cycles after reset release (zero-wait).
//  T3 width: LI r1,0; LI r2,1; SUB r3,r1,r2 -> r3=0xFFFF. SLT r4,r3,r2 -> 1. SHLI by 15 and by 0 on 0x0001 -> 0x8000 and 0x0001.
//  T4 branch: r1=3, r2=1; loop {SUB r1,r1,r2; OUT r1; BNEZ r1,-3} -> out_data sequence 2,1,0, then fall-through; JMP 0xFFF with PC_W=12 lands at 0xFFF.
//  T5 wait states: imem_valid delayed 3 cycles on every fetch -> imem_addr stable while requested, results identical to T2, 7 cycles/instr.
//  T6 edge: LI r0,9; OUT r0 -> out_data=0. HALT -> halted=1, pc frozen for 20 cycles; reset then restarts fetch at 0.

Source files
------------

// File: rtl/proc_core_mc.sv
// rtl/proc_core_mc.sv - parametrised multicycle 16-bit-ISA core with FETCH/DECODE/EXEC/WB/HALT control
module proc_core_mc #(
  parameter int DATA_W   = 16,
  parameter int PC_W     = 12,
  parameter int RESET_PC = 0
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_valid,
  input  logic [15:0]       imem_rdata,
  output logic [PC_W-1:0]   pc,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              halted
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_SHLI = 4'd7;
  localparam logic [3:0] OP_SHRI = 4'd8;
  localparam logic [3:0] OP_LI   = 4'd9;
  localparam logic [3:0] OP_BEQZ = 4'd10;
  localparam logic [3:0] OP_BNEZ = 4'd11;
  localparam logic [3:0] OP_JMP  = 4'd12;
  localparam logic [3:0] OP_OUT  = 4'd13;
  localparam logic [3:0] OP_HALT = 4'd15;

  state_t            state;
  logic [15:0]       ir;
  logic [DATA_W-1:0] rf [16];
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] res;
  logic              zf;

  logic [3:0]        op;
  logic [3:0]        rd;
  logic [3:0]        rs;
  logic [3:0]        rt;
  logic [3:0]        imm4;
  logic [7:0]        imm8;
  logic              is_branch;
  logic [DATA_W-1:0] alu_y;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   br_off;
  logic [PC_W-1:0]   pc_next;

  assign op        = ir[15:12];
  assign rd        = ir[11:8];
  assign rs        = ir[7:4];
  assign rt        = ir[3:0];
  assign imm4      = ir[7:4];
  assign imm8      = ir[7:0];
  assign is_branch = (op == OP_BEQZ) || (op == OP_BNEZ);

  // Requests only in FETCH, and never while reset is being held low.
  assign imem_req  = (state == S_FETCH) && reset;
  assign imem_addr = pc;

  // ALU on the operands latched in DECODE; shifts by >= DATA_W naturally give zero.
  always_comb begin
    alu_y = '0;
    case (op)
      OP_ADD:  alu_y = a + b;
      OP_SUB:  alu_y = a - b;
      OP_AND:  alu_y = a & b;
      OP_OR:   alu_y = a | b;
      OP_XOR:  alu_y = a ^ b;
      OP_SLT:  alu_y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_ADDI: alu_y = b + DATA_W'(imm4);
      OP_SHLI: alu_y = b << imm4;
      OP_SHRI: alu_y = b >> imm4;
      OP_LI:   alu_y = DATA_W'(imm8);
      default: alu_y = '0;
    endcase
  end

  // Next PC: taken branch is relative to pc+1, JMP is absolute, everything else falls through.
  always_comb begin
    pc_inc  = pc + PC_W'(1);
    br_off  = PC_W'({{8{imm8[7]}}, imm8});
    pc_next = pc_inc;
    if (((op == OP_BEQZ) && zf) || ((op == OP_BNEZ) && !zf))
      pc_next = pc_inc + br_off;
    else if (op == OP_JMP)
      pc_next = ir[PC_W-1:0];
  end

  // Control FSM with register file, PC and registered debug outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state     <= S_FETCH;
      pc        <= PC_W'(RESET_PC);
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      res       <= '0;
      zf        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      halted    <= 1'b0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_FETCH: begin
          if (imem_valid) begin
            ir    <= imem_rdata;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          a     <= is_branch ? rf[rd] : rf[rs];
          b     <= rf[rt];
          state <= S_EXEC;
        end
        S_EXEC: begin
          res   <= alu_y;
          zf    <= (a == '0);
          state <= S_WB;
        end
        S_WB: begin
          // rf[0] is never written, so it keeps reading as zero.
          if ((op <= OP_LI) && (rd != 4'd0)) rf[rd] <= res;
          pc <= pc_next;
          if (op == OP_OUT) begin
            out_valid <= 1'b1;
            out_data  <= a;
          end
          if (op == OP_HALT) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            state <= S_FETCH;
          end
        end
        S_HALT: ;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_core_mc.sv
// tb/tb_proc_core_mc.sv - self-checking bench for proc_core_mc against an ISA-level model
module tb_proc_core_mc;
  localparam int DW = 16;
  localparam int PW = 12;
  localparam logic [15:0] HALT_W = 16'hF000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_valid = 1'b0;
  logic [15:0]   imem_rdata = 16'h0;
  logic [PW-1:0] pc;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          halted;

  always #5 clk = ~clk;

  proc_core_mc #(.DATA_W(DW), .PC_W(PW), .RESET_PC(0)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_valid(imem_valid),
    .imem_rdata(imem_rdata),
    .pc        (pc),
    .out_valid (out_valid),
    .out_data  (out_data),
    .halted    (halted)
  );

  logic [15:0]   rom [0:4095];
  int            waitn = 0;
  int            wcnt = 0;
  int            wtarget = 0;
  bit            pend = 1'b0;
  logic [PW-1:0] paddr = '0;
  int            unstable = 0;
  int            last_fetch = 0;
  int            cyc = 0;
  int            got_outs[$];
  int            got_cycs[$];
  int            exp_outs[$];
  int            exp_pc;
  int            exp_halted;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ins(input int op, input int rd, input int rs, input int rt);
    return {op[3:0], rd[3:0], rs[3:0], rt[3:0]};
  endfunction

  function automatic int qget(input int i);
    return (got_outs.size() > i) ? got_outs[i] : -1;
  endfunction

  function automatic int qcyc(input int i);
    return (got_cycs.size() > i) ? got_cycs[i] : -1;
  endfunction

  function automatic int sgn(input int x);
    return (x >= (1 << (DW - 1))) ? x - (1 << DW) : x;
  endfunction

  // Instruction memory: programmable wait states, junk on the bus when not requested.
  always @(negedge clk) begin
    if (!reset || !imem_req) begin
      imem_valid = 1'($urandom_range(0, 1));
      imem_rdata = 16'($urandom);
      wcnt       = 0;
      pend       = 1'b0;
      wtarget    = (waitn < 0) ? $urandom_range(0, 2) : waitn;
    end else begin
      if (pend && imem_addr != paddr) unstable++;
      if (wcnt >= wtarget) begin
        imem_valid = 1'b1;
        imem_rdata = rom[imem_addr];
        last_fetch = imem_addr;
        pend       = 1'b0;
      end else begin
        imem_valid = 1'b0;
        imem_rdata = 16'($urandom);
        wcnt++;
        pend = 1'b1;
      end
      paddr = imem_addr;
    end
  end

  // Cycle counter since reset release and OUT capture.
  always @(posedge clk) begin
    if (!reset) cyc = 0;
    else cyc++;
    #1;
    if (out_valid) begin
      got_outs.push_back(int'(out_data));
      got_cycs.push_back(cyc);
    end
  end

  // Reference interpreter: one instruction per step, no notion of cycles.
  task automatic run_model();
    int r[16];
    int p, steps, op, rd, rs, rt, i4, i8, sx, va, vb, v, np;
    logic [15:0] w;
    bit h;
    int m, pm;
    m = (1 << DW) - 1;
    pm = (1 << PW) - 1;
    for (int i = 0; i < 16; i++) r[i] = 0;
    exp_outs.delete();
    p = 0; steps = 0; h = 0;
    while (!h && steps < 3000) begin
      w  = rom[p];
      op = int'(w[15:12]); rd = int'(w[11:8]); rs = int'(w[7:4]); rt = int'(w[3:0]);
      i4 = rs; i8 = int'(w[7:0]);
      sx = (i8 >= 128) ? i8 - 256 : i8;
      va = r[rs]; vb = r[rt]; v = 0;
      np = (p + 1) & pm;
      case (op)
        0:  v = (va + vb) & m;
        1:  v = (va - vb) & m;
        2:  v = va & vb;
        3:  v = va | vb;
        4:  v = va ^ vb;
        5:  v = (sgn(va) < sgn(vb)) ? 1 : 0;
        6:  v = (vb + i4) & m;
        7:  v = (i4 >= DW) ? 0 : (vb << i4) & m;
        8:  v = (i4 >= DW) ? 0 : (vb >> i4);
        9:  v = i8;
        10: if (r[rd] == 0) np = (p + 1 + sx) & pm;
        11: if (r[rd] != 0) np = (p + 1 + sx) & pm;
        12: np = int'(w[11:0]) & pm;
        13: exp_outs.push_back(va);
        15: h = 1;
        default: ;
      endcase
      if (op <= 9 && rd != 0) r[rd] = v;
      p = np;
      steps++;
    end
    exp_pc = p;
    exp_halted = h;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = HALT_W;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    got_outs.delete();
    got_cycs.delete();
    unstable = 0;
  endtask

  task automatic run_prog(input string tag, input int w, input int budget);
    int n;
    run_model();
    waitn = w;
    do_reset();
    for (int i = 0; i < budget && !halted; i++) @(negedge clk);
    chk({tag, "_halted"}, int'(halted), exp_halted);
    chk({tag, "_nout"}, got_outs.size(), exp_outs.size());
    n = (got_outs.size() < exp_outs.size()) ? got_outs.size() : exp_outs.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_out%0d", tag, i), got_outs[i], exp_outs[i]);
    chk({tag, "_pc"}, int'(pc), exp_pc);
    chk({tag, "_addr_stable"}, unstable, 0);
  endtask

  task automatic reset_check(input string tag);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag, "_rst_pc"}, int'(pc), 0);
    chk({tag, "_rst_halted"}, int'(halted), 0);
    chk({tag, "_rst_req"}, int'(imem_req), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk({tag, "_rel_req"}, int'(imem_req), 1);
    chk({tag, "_rel_addr"}, int'(imem_addr), 0);
  endtask

  task automatic load_t2();
    clear_rom();
    rom[0] = ins(9, 1, 0, 5);
    rom[1] = ins(9, 2, 0, 7);
    rom[2] = ins(0, 3, 1, 2);
    rom[3] = ins(13, 0, 3, 0);
  endtask

  task automatic load_t4();
    clear_rom();
    rom[0] = ins(9, 1, 0, 3);
    rom[1] = ins(9, 2, 0, 1);
    rom[2] = ins(1, 1, 1, 2);
    rom[3] = ins(13, 0, 1, 0);
    rom[4] = ins(11, 1, 15, 13);
    rom[5] = ins(12, 15, 15, 15);
  endtask

  initial begin
    logic [15:0] w;
    int op;
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    int op;

    // T2: ALU path, zero-wait latency
    load_t2();
    run_prog("t2", 0, 200);
    chk("t2_val", qget(0), 12);
    chk("t2_cyc", qcyc(0), 16);

    // T5: same program with three wait cycles per fetch
    run_prog("t5", 3, 400);
    chk("t5_val", qget(0), 12);
    chk("t5_cyc", qcyc(0), 28);

    // T3: width wrap, signed compare, shift extremes
    clear_rom();
    rom[0]  = ins(9, 1, 0, 0);
    rom[1]  = ins(9, 2, 0, 1);
    rom[2]  = ins(1, 3, 1, 2);
    rom[3]  = ins(13, 0, 3, 0);
    rom[4]  = ins(5, 4, 3, 2);
    rom[5]  = ins(13, 0, 4, 0);
    rom[6]  = ins(9, 5, 0, 1);
    rom[7]  = ins(7, 6, 15, 5);
    rom[8]  = ins(13, 0, 6, 0);
    rom[9]  = ins(7, 7, 0, 5);
    rom[10] = ins(13, 0, 7, 0);
    run_prog("t3", 0, 300);
    chk("t3_sub", qget(0), 'hFFFF);
    chk("t3_slt", qget(1), 1);
    chk("t3_shl15", qget(2), 'h8000);
    chk("t3_shl0", qget(3), 1);

    // T4: backward branch loop then JMP to the top address, PC wraps after HALT there
    load_t4();
    run_prog("t4", 0, 400);
    chk("t4_o0", qget(0), 2);
    chk("t4_o1", qget(1), 1);
    chk("t4_o2", qget(2), 0);
    chk("t4_jmp_fetch", last_fetch, 'hFFF);
    chk("t4_pc_wrap", int'(pc), 0);

    // T1: reset in the middle of a program with random wait states
    load_t4();
    waitn = -1;
    do_reset();
    repeat (30) @(negedge clk);
    reset_check("t1");

    // T6: R0 is hardwired zero, HALT freezes the core until reset
    clear_rom();
    rom[0] = ins(9, 0, 0, 9);
    rom[1] = ins(13, 0, 0, 0);
    run_prog("t6", 0, 200);
    chk("t6_r0", qget(0), 0);
    repeat (20) @(negedge clk);
    chk("t6_pc_frozen", int'(pc), 3);
    chk("t6_halted", int'(halted), 1);
    chk("t6_req_low", int'(imem_req), 0);
    chk("t6_no_more_out", got_outs.size(), 1);
    reset_check("t6");

    // Random programs: forward-only control flow, then dump every register
    for (int t = 0; t < 6; t++) begin
      clear_rom();
      for (int i = 0; i < 40; i++) begin
        op = $urandom_range(0, 14);
        w = 16'($urandom);
        w[15:12] = op[3:0];
        if (op == 10 || op == 11) w[7:0] = 8'($urandom_range(0, 3));
        if (op == 12) w[11:0] = 12'(i + 1 + $urandom_range(0, 3));
        rom[i] = w;
      end
      for (int r = 1; r < 16; r++) rom[39 + r] = ins(13, 0, r, 0);
      run_prog($sformatf("rnd%0d", t), -1, 2000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
